// File: rtl/vx_warp_ibuf.sv
// Per-warp instruction FIFOs that feed one registered, round-robin arbitrated issue port.
// Optional: define IBUF_PERF_EN to count decode stall cycles on perf_ibf_stalls.
module vx_warp_ibuf #(
    parameter int NUM_WARPS     = 4,
    parameter int NW_BITS       = $clog2(NUM_WARPS),
    parameter int IBUF_SIZE     = 2,
    parameter int DATAW         = 64,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     decode_valid,
    input  logic [NW_BITS-1:0]       decode_wid,
    input  logic [DATAW-1:0]         decode_data,
    output logic                     decode_ready,
    output logic                     ibuf_valid,
    output logic [NW_BITS-1:0]       ibuf_wid,
    output logic [DATAW-1:0]         ibuf_data,
    input  logic                     ibuf_ready,
    output logic [NUM_WARPS-1:0]     warp_full,
    output logic [PERF_CTR_BITS-1:0] perf_ibf_stalls
);

    localparam int PTR_BITS = $clog2(IBUF_SIZE);
    localparam int CNT_BITS = $clog2(IBUF_SIZE + 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(IBUF_SIZE);

    logic [DATAW-1:0]    mem   [NUM_WARPS][IBUF_SIZE];
    logic [PTR_BITS-1:0] wptr  [NUM_WARPS];
    logic [PTR_BITS-1:0] rptr  [NUM_WARPS];
    logic [CNT_BITS-1:0] count [NUM_WARPS];
    logic [NW_BITS-1:0]  rr_last;

    logic                 enq;
    logic                 load;
    logic                 deq;
    logic                 deq_found;
    logic [NW_BITS-1:0]   deq_wid;
    logic [NW_BITS-1:0]   cand;
    logic [NUM_WARPS-1:0] enq_mask;
    logic [NUM_WARPS-1:0] deq_mask;

    assign decode_ready = (count[decode_wid] != FULL_CNT);
    assign enq          = decode_valid && decode_ready;
    assign load         = !ibuf_valid || ibuf_ready;
    assign deq          = load && deq_found;
    assign enq_mask     = enq ? (NUM_WARPS'(1) << decode_wid) : '0;
    assign deq_mask     = deq ? (NUM_WARPS'(1) << deq_wid) : '0;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_full[w] = (count[w] == FULL_CNT);
        end
    end

    // Search starts just past the last winner; offset NUM_WARPS wraps back to rr_last itself.
    always_comb begin
        deq_found = 1'b0;
        deq_wid   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand = rr_last + NW_BITS'(i);
            if (!deq_found && count[cand] != '0) begin
                deq_found = 1'b1;
                deq_wid   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                wptr[w]  <= '0;
                rptr[w]  <= '0;
                count[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (enq_mask[w]) begin
                    wptr[w] <= wptr[w] + PTR_BITS'(1);
                end
                if (deq_mask[w]) begin
                    rptr[w] <= rptr[w] + PTR_BITS'(1);
                end
                if (enq_mask[w] && !deq_mask[w]) begin
                    count[w] <= count[w] + CNT_BITS'(1);
                end else if (!enq_mask[w] && deq_mask[w]) begin
                    count[w] <= count[w] - CNT_BITS'(1);
                end
            end
        end
    end

    // Payload storage is deliberately left unreset; counts gate every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[decode_wid][wptr[decode_wid]] <= decode_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ibuf_valid <= 1'b0;
            ibuf_wid   <= '0;
            ibuf_data  <= '0;
            rr_last    <= NW_BITS'(NUM_WARPS - 1);
        end else if (load) begin
            ibuf_valid <= deq_found;
            if (deq_found) begin
                ibuf_wid  <= deq_wid;
                ibuf_data <= mem[deq_wid][rptr[deq_wid]];
                rr_last   <= deq_wid;
            end
        end
    end

`ifdef IBUF_PERF_EN
    logic [PERF_CTR_BITS-1:0] stall_ctr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_ctr <= '0;
        end else if (decode_valid && !decode_ready) begin
            stall_ctr <= stall_ctr + PERF_CTR_BITS'(1);
        end
    end

    assign perf_ibf_stalls = stall_ctr;
`else
    assign perf_ibf_stalls = '0;
`endif

endmodule

// File: tb/tb_vx_warp_ibuf.sv
// Testbench for vx_warp_ibuf: queue-based reference model, output scoreboard, directed and random traffic.
module tb_vx_warp_ibuf;

    localparam int NUM_WARPS = 4;
    localparam int IBUF_SIZE = 2;
`ifdef IBUF_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  wid;
        logic [63:0] data;
    } out_t;

    logic        clk;
    logic        reset;
    logic        decode_valid;
    logic [1:0]  decode_wid;
    logic [63:0] decode_data;
    logic        decode_ready;
    logic        ibuf_valid;
    logic [1:0]  ibuf_wid;
    logic [63:0] ibuf_data;
    logic        ibuf_ready;
    logic [3:0]  warp_full;
    logic [43:0] perf_ibf_stalls;

    int total = 0;
    int bad   = 0;

    logic [63:0]     fifo_q [NUM_WARPS][$];
    out_t            exp_q [$];
    out_t            m_entry;
    out_t            mon_entry;
    bit              m_valid;
    int              m_rr;
    bit              m_found;
    bit              m_stall;
    longint unsigned m_stalls;
    logic [3:0]      m_full;

    vx_warp_ibuf dut (
        .clk             (clk),
        .reset           (reset),
        .decode_valid    (decode_valid),
        .decode_wid      (decode_wid),
        .decode_data     (decode_data),
        .decode_ready    (decode_ready),
        .ibuf_valid      (ibuf_valid),
        .ibuf_wid        (ibuf_wid),
        .ibuf_data       (ibuf_data),
        .ibuf_ready      (ibuf_ready),
        .warp_full       (warp_full),
        .perf_ibf_stalls (perf_ibf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] exp_perf();
        return PERF_ON ? 64'(m_stalls) : 64'd0;
    endfunction

    // Reference model: each warp is a plain queue; on an output load the first non-empty
    // warp after the previous winner hands its oldest entry to the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) fifo_q[w].delete();
            exp_q.delete();
            m_valid  = 1'b0;
            m_rr     = NUM_WARPS - 1;
            m_stalls = 0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) m_full[w] = (fifo_q[w].size() == IBUF_SIZE);
            check_output("decode_ready", 64'(decode_ready), 64'(fifo_q[decode_wid].size() != IBUF_SIZE));
            check_output("warp_full", 64'(warp_full), 64'(m_full));
            check_output("ibuf_valid", 64'(ibuf_valid), 64'(m_valid));
            check_output("perf_ibf_stalls", 64'(perf_ibf_stalls), exp_perf());

            m_stall = decode_valid && (fifo_q[decode_wid].size() == IBUF_SIZE);
            if (!m_valid || ibuf_ready) begin
                m_found = 1'b0;
                for (int k = 1; k <= NUM_WARPS; k++) begin
                    if (!m_found && fifo_q[(m_rr + k) % NUM_WARPS].size() > 0) begin
                        m_found      = 1'b1;
                        m_rr         = (m_rr + k) % NUM_WARPS;
                        m_entry.wid  = 2'(m_rr);
                        m_entry.data = fifo_q[m_rr].pop_front();
                        exp_q.push_back(m_entry);
                    end
                end
                m_valid = m_found;
            end
            if (decode_valid && !m_stall) fifo_q[decode_wid].push_back(decode_data);
            if (m_stall) m_stalls++;
        end
    end

    always @(negedge clk) begin
        if (reset && ibuf_valid && ibuf_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_underflow: actual wid=%0d data=%0h required=no output", ibuf_wid, ibuf_data);
            end else begin
                mon_entry = exp_q.pop_front();
                check_output("sb_wid", 64'(ibuf_wid), 64'(mon_entry.wid));
                check_output("sb_data", ibuf_data, mon_entry.data);
            end
        end
    end

    task automatic apply_stimulus(input logic v, input logic [1:0] w, input logic [63:0] d, input logic r);
        @(posedge clk);
        #2;
        decode_valid = v;
        decode_wid   = w;
        decode_data  = d;
        ibuf_ready   = r;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset        = 1'b0;
        decode_valid = 1'b0;
        decode_wid   = '0;
        decode_data  = '0;
        ibuf_ready   = 1'b0;
        @(negedge clk);
        check_output("rst_ibuf_valid", 64'(ibuf_valid), 64'd0);
        check_output("rst_ibuf_wid", 64'(ibuf_wid), 64'd0);
        check_output("rst_ibuf_data", ibuf_data, 64'd0);
        check_output("rst_warp_full", 64'(warp_full), 64'd0);
        check_output("rst_decode_ready", 64'(decode_ready), 64'd1);
        check_output("rst_perf", 64'(perf_ibf_stalls), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic drain(input int cycles);
        apply_stimulus(1'b0, 2'd0, 64'd0, 1'b1);
        repeat (cycles) @(posedge clk);
    endtask

    logic [1:0]  rr_wid  [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [63:0] rr_data [6] = '{64'hC00, 64'hC10, 64'hC30, 64'hC01, 64'hC11, 64'hC31};
    logic [1:0]  pre_wid [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3};
    logic [63:0] pre_data[6] = '{64'hC00, 64'hC01, 64'hC10, 64'hC11, 64'hC30, 64'hC31};

    initial begin
        reset        = 1'b0;
        decode_valid = 1'b0;
        decode_wid   = '0;
        decode_data  = '0;
        ibuf_ready   = 1'b0;

        // Basic flow: two-edge latency, then the output empties.
        apply_reset();
        apply_stimulus(1'b1, 2'd0, 64'hA1, 1'b1);
        apply_stimulus(1'b0, 2'd0, 64'd0, 1'b1);
        @(negedge clk);
        check_output("basic_early_valid", 64'(ibuf_valid), 64'd0);
        @(negedge clk);
        check_output("basic_valid", 64'(ibuf_valid), 64'd1);
        check_output("basic_wid", 64'(ibuf_wid), 64'd0);
        check_output("basic_data", ibuf_data, 64'hA1);
        @(negedge clk);
        check_output("basic_drop_valid", 64'(ibuf_valid), 64'd0);

        // Full warp under backpressure, then two stall cycles.
        apply_reset();
        apply_stimulus(1'b1, 2'd2, 64'hB1, 1'b0);
        apply_stimulus(1'b1, 2'd2, 64'hB2, 1'b0);
        apply_stimulus(1'b1, 2'd2, 64'hB3, 1'b0);
        apply_stimulus(1'b1, 2'd2, 64'hB4, 1'b0);
        @(negedge clk);
        check_output("full_warp_full", 64'(warp_full), 64'b0100);
        check_output("full_decode_ready", 64'(decode_ready), 64'd0);
        check_output("full_out_data", ibuf_data, 64'hB1);
        apply_stimulus(1'b1, 2'd2, 64'hB4, 1'b0);
        apply_stimulus(1'b0, 2'd0, 64'd0, 1'b0);
        @(negedge clk);
        check_output("full_perf", 64'(perf_ibf_stalls), PERF_ON ? 64'd2 : 64'd0);
        drain(5);

        // Round-robin across warps 0, 1, 3.
        apply_reset();
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, pre_wid[i], pre_data[i], 1'b0);
        apply_stimulus(1'b0, 2'd0, 64'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("rr_valid", 64'(ibuf_valid), 64'd1);
            check_output("rr_wid", 64'(ibuf_wid), 64'(rr_wid[i]));
            check_output("rr_data", ibuf_data, rr_data[i]);
        end
        drain(3);

        // Full warp dequeued while decode presents the same warp.
        apply_reset();
        apply_stimulus(1'b1, 2'd1, 64'hD0, 1'b0);
        apply_stimulus(1'b1, 2'd1, 64'hD1, 1'b0);
        apply_stimulus(1'b1, 2'd1, 64'hD2, 1'b0);
        apply_stimulus(1'b1, 2'd1, 64'hD3, 1'b1);
        @(negedge clk);
        check_output("simul_ready_lo", 64'(decode_ready), 64'd0);
        @(negedge clk);
        check_output("simul_ready_hi", 64'(decode_ready), 64'd1);
        drain(6);

        // Output stays put under backpressure while other warps enqueue.
        apply_reset();
        apply_stimulus(1'b1, 2'd0, 64'hE0, 1'b0);
        apply_stimulus(1'b0, 2'd0, 64'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 2'(1 + (i % 3)), 64'hE10 + 64'(i), 1'b0);
            @(negedge clk);
            check_output("stable_valid", 64'(ibuf_valid), 64'd1);
            check_output("stable_wid", 64'(ibuf_wid), 64'd0);
            check_output("stable_data", ibuf_data, 64'hE0);
        end
        drain(8);

        // Asynchronous reset with warps partly full.
        apply_reset();
        apply_stimulus(1'b1, 2'd2, 64'hF0, 1'b0);
        apply_stimulus(1'b1, 2'd2, 64'hF1, 1'b0);
        apply_stimulus(1'b1, 2'd2, 64'hF2, 1'b0);
        apply_stimulus(1'b1, 2'd2, 64'hF3, 1'b0);
        apply_stimulus(1'b1, 2'd0, 64'hF4, 1'b0);
        apply_stimulus(1'b0, 2'd0, 64'd0, 1'b0);
        @(negedge clk);
        check_output("areset_pre_full", 64'(warp_full[2]), 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_output("areset_valid", 64'(ibuf_valid), 64'd0);
        check_output("areset_full", 64'(warp_full), 64'd0);
        check_output("areset_perf", 64'(perf_ibf_stalls), 64'd0);
        check_output("areset_ready", 64'(decode_ready), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Random traffic against the model.
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            apply_stimulus($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                           {$urandom, $urandom}, $urandom_range(0, 9) < 6);
        end
        drain(12);
        @(negedge clk);
        check_output("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        check_output("drain_valid", 64'(ibuf_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vx_warp_ibuf.md
# vx_warp_ibuf

Per-warp instruction buffer sitting between the decode stage and the issue stage. Accepts decoded instructions tagged with a warp ID, holds them in independent per-warp FIFOs, and presents one instruction per cycle to issue through a registered valid/ready output, choosing warps round-robin. Keeps a stalled warp from blocking the others and reports per-warp fullness back to the warp scheduler.

## Interface
- NUM_WARPS, 4, number of warps; power of 2, ≥2
- NW_BITS, $clog2(NUM_WARPS), warp ID width
- IBUF_SIZE, 2, entries per warp FIFO; power of 2, ≥2
- DATAW, 64, opaque decoded-instruction payload width
- PERF_CTR_BITS, 44, perf counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- decode_valid  in  1  decoded instruction present
- decode_wid  in  NW_BITS  warp of the incoming instruction
- decode_data  in  DATAW  instruction payload
- decode_ready  out  1  buffer for decode_wid can accept
- ibuf_valid  out  1  registered output instruction valid
- ibuf_wid  out  NW_BITS  warp of the output instruction
- ibuf_data  out  DATAW  output payload
- ibuf_ready  in  1  issue accepts the output
- warp_full  out  NUM_WARPS  bit w = warp w FIFO holds IBUF_SIZE entries
- perf_ibf_stalls  out  PERF_CTR_BITS  decode stall cycles (macro-gated)

## Operation
- State per warp: write pointer, read pointer, count (0..IBUF_SIZE), IBUF_SIZE×DATAW storage. Global state: output register (valid, wid, data) and round-robin pointer rr_last.
- decode_ready = (count[decode_wid] != IBUF_SIZE). It is combinational and depends only on registered count and decode_wid. It does not depend on decode_valid.
- Enqueue when decode_valid && decode_ready: write to the decode_wid FIFO at wptr, then increment wptr (wraps modulo IBUF_SIZE).
- Output register load enable: load = !ibuf_valid || ibuf_ready.
- Arbitration when load is high:
  - The candidates are the warps with count > 0, using counts registered before this cycle's enqueue.
  - Priority starts at rr_last+1 and proceeds upward modulo NUM_WARPS.
  - The winner is dequeued: its head entry goes to ibuf_data and ibuf_wid, its rptr is incremented, ibuf_valid is set to 1, and rr_last takes the winner's value.
- No candidate and load high: ibuf_valid is cleared. ibuf_wid and ibuf_data hold their values.
- Same warp enqueued and dequeued in one cycle: count is unchanged and both pointers advance.
- Program order within a warp is strictly preserved. There is no ordering guarantee across warps.
- warp_full[w] = (count[w] == IBUF_SIZE), registered-state derived.
- Output holds stable (valid, wid, data) while ibuf_valid && !ibuf_ready.

## Timing
- Reset (reset low, asynchronous) sets the following:
  - All counts and pointers are 0.
  - ibuf_valid = 0, ibuf_wid = 0, ibuf_data = 0.
  - rr_last = NUM_WARPS-1, so warp 0 wins first.
  - perf_ibf_stalls = 0.
  - warp_full = 0 and decode_ready = 1.
  - Storage contents are not reset.
- Reset mid-operation drops all buffered instructions. Deassertion is synchronised externally.
- Minimum latency: enqueue accepted at edge N, ibuf_valid high after edge N+1. This is 2 cycles and there is no bypass path.
- Throughput: 1 enqueue and 1 dequeue per cycle sustained.
- A full warp accepts a new enqueue in the cycle after its dequeue edge, not in the same cycle.

## Configuration
- IBUF_PERF_EN defined:
  - perf_ibf_stalls increments by 1 on each cycle with decode_valid && !decode_ready.
  - It wraps at 2^PERF_CTR_BITS.
- IBUF_PERF_EN undefined:
  - The counter logic is absent and perf_ibf_stalls is tied to 0.
  - The port remains, so the interface is identical.

## Test plan
- Basic flow:
  - Stimulus: after reset, enqueue wid=0 data=0xA1 with ibuf_ready=1.
  - Required response: ibuf_valid=1, wid=0, data=0xA1 two edges later, and ibuf_valid=0 after the next edge.
- Full/backpressure:
  - Stimulus: hold ibuf_ready=0, then enqueue 3 instructions to wid=2 (IBUF_SIZE=2).
  - Required response: the first instruction loads into the output register and the next two fill the FIFO. warp_full[2]=1 and decode_ready=0 for the 4th.
  - With IBUF_PERF_EN, 2 stall cycles give perf_ibf_stalls=2.
- Round-robin fairness:
  - Stimulus: preload 2 entries each in warps 0, 1, 3, then hold ibuf_ready=1.
  - Required response: wid output order 0,1,3,0,1,3, with per-warp data in insertion order.
- Simultaneous enqueue/dequeue:
  - Stimulus: warp 1 is full and, in one cycle, is dequeued while decode presents wid=1.
  - Required response: decode_ready=0 that cycle, then 1 the next cycle. The count stays bounded and no entry is lost or duplicated.
- Output stability:
  - Stimulus: ibuf_valid=1 with ibuf_ready=0 for 5 cycles while other warps enqueue.
  - Required response: ibuf_wid/ibuf_data remain unchanged.
- Async reset mid-stream:
  - Stimulus: assert reset low between clock edges with warps partially full.
  - Required response: ibuf_valid=0, warp_full=0, and perf_ibf_stalls=0 immediately, without waiting for a clock edge.
